// File: rtl/lock_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// lock_pkg : shared state encoding and defaults for the lock controller
// Rev 1.0
// ----------------------------------------------------------------------
package lock_pkg;

  localparam int LOCK_DIGITS    = 4;
  localparam int LOCK_MAX_TRIES = 3;

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_PROG    = 3'd4,
    S_LOCKOUT = 3'd5
  } lock_state_t;

endpackage
`default_nettype wire

// File: rtl/lock_timer.sv
`default_nettype none
// ----------------------------------------------------------------------
// lock_timer : loadable down-counter that parks at zero
// Rev 1.0
// ----------------------------------------------------------------------
module lock_timer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_value;
    end else if (i_en && (r_value != '0)) begin
      r_value <= r_value - 1'b1;
    end
  end

  assign o_value = r_value;
  assign o_zero  = (r_value == '0);

endmodule
`default_nettype wire

// File: rtl/lock_controller.sv
`default_nettype none
// ----------------------------------------------------------------------
// lock_controller : keypad combination-lock FSM with duress and lockout
// Rev 1.0
// ----------------------------------------------------------------------
module lock_controller
  import lock_pkg::*;
#(
  parameter int DIGITS         = LOCK_DIGITS,
  parameter int MAX_TRIES      = LOCK_MAX_TRIES,
  parameter int UNLOCK_CYCLES  = 100000000,
  parameter int LOCKOUT_CYCLES = 500000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_Validate,
  input  logic       i_Prog,
  input  logic       i_Lock,
  input  logic       i_Pass,
  input  logic       i_Reverse,
  output logic       o_ShiftA,
  output logic       o_ShiftB,
  output logic       o_RSTA,
  output logic       o_Unlocked,
  output logic       o_LockedOut,
  output logic       o_Duress,
  output logic [2:0] o_DigitCount,
  output logic [1:0] o_Tries
);

  localparam logic [2:0]  C_DIGITS       = 3'(DIGITS);
  localparam logic [1:0]  C_MAX_TRIES    = 2'(MAX_TRIES);
  localparam logic [31:0] C_UNLOCK_LOAD  = 32'(UNLOCK_CYCLES - 1);
  localparam logic [31:0] C_LOCKOUT_LOAD = 32'(LOCKOUT_CYCLES - 1);

  lock_state_t r_state;
  lock_state_t w_next;

  logic [2:0]  r_digit_count;
  logic [1:0]  r_tries;
  logic        r_duress;
  logic        r_shift_a;
  logic        r_shift_b;
  logic        r_rsta;
  logic        r_unlocked;
  logic        r_locked_out;

  logic [2:0]  w_digit_inc;
  logic [1:0]  w_tries_inc;
  logic        w_digit_done;
  logic        w_timer_load;
  logic        w_timer_en;
  logic        w_timer_zero;
  logic [31:0] w_timer_load_value;
  logic [31:0] w_timer_value;

  assign w_digit_inc  = r_digit_count + 3'd1;
  assign w_tries_inc  = r_tries + 2'd1;
  assign w_digit_done = i_Validate && (w_digit_inc == C_DIGITS);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR: w_next = S_ENTRY;
      S_ENTRY: if (w_digit_done) w_next = S_CHECK;
      S_CHECK: begin
        if (i_Pass || i_Reverse)          w_next = S_OPEN;
        else if (w_tries_inc == C_MAX_TRIES) w_next = S_LOCKOUT;
        else                              w_next = S_CLEAR;
      end
      S_OPEN: begin
        // Lock has priority over Prog when both arrive together
        if (i_Lock || w_timer_zero) w_next = S_CLEAR;
        else if (i_Prog)            w_next = S_PROG;
      end
      S_PROG:    if (w_digit_done) w_next = S_CLEAR;
      S_LOCKOUT: if (w_timer_zero) w_next = S_CLEAR;
      default:   w_next = S_CLEAR;
    endcase
  end

  // One timer serves both windows; it is armed on the edge entering each.
  assign w_timer_load = ((w_next == S_OPEN) && (r_state != S_OPEN)) ||
                        ((w_next == S_LOCKOUT) && (r_state != S_LOCKOUT));
  assign w_timer_load_value = (w_next == S_LOCKOUT) ? C_LOCKOUT_LOAD : C_UNLOCK_LOAD;
  assign w_timer_en = (r_state == S_OPEN) || (r_state == S_LOCKOUT);

  lock_timer #(
    .WIDTH(32)
  ) u_timer (
    .CLK         (CLK),
    .RST         (RST),
    .i_load      (w_timer_load),
    .i_en        (w_timer_en),
    .i_load_value(w_timer_load_value),
    .o_value     (w_timer_value),
    .o_zero      (w_timer_zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= S_CLEAR;
      r_digit_count <= 3'd0;
      r_tries       <= 2'd0;
      r_duress      <= 1'b0;
      r_rsta        <= 1'b1;
      r_shift_a     <= 1'b0;
      r_shift_b     <= 1'b0;
      r_unlocked    <= 1'b0;
      r_locked_out  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_rsta       <= (w_next == S_CLEAR);
      r_shift_a    <= (w_next == S_ENTRY);
      r_shift_b    <= (w_next == S_PROG);
      r_unlocked   <= (w_next == S_OPEN) || (w_next == S_PROG);
      r_locked_out <= (w_next == S_LOCKOUT);
      case (r_state)
        S_CLEAR: r_digit_count <= 3'd0;
        S_ENTRY, S_PROG: if (i_Validate) r_digit_count <= w_digit_inc;
        S_CHECK: begin
          r_digit_count <= 3'd0;
          if (i_Pass || i_Reverse) begin
            r_tries <= 2'd0;
            if (!i_Pass) r_duress <= 1'b1;
          end else begin
            r_tries <= w_tries_inc;
          end
        end
        S_OPEN: if (!i_Lock && !w_timer_zero && i_Prog) r_digit_count <= 3'd0;
        S_LOCKOUT: if (w_timer_zero) r_tries <= 2'd0;
        default: r_digit_count <= 3'd0;
      endcase
    end
  end

  assign o_ShiftA     = r_shift_a;
  assign o_ShiftB     = r_shift_b;
  assign o_RSTA       = r_rsta;
  assign o_Unlocked   = r_unlocked;
  assign o_LockedOut  = r_locked_out;
  assign o_Duress     = r_duress;
  assign o_DigitCount = r_digit_count;
  assign o_Tries      = r_tries;

endmodule
`default_nettype wire

// File: tb/tb_lock_controller.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_lock_controller : directed bench with a keypad datapath attached
// Rev 1.0
// ----------------------------------------------------------------------
module tb_lock_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Validate = 1'b0;
  logic       Prog = 1'b0;
  logic       Lock = 1'b0;
  logic [3:0] key = 4'h0;
  logic       Pass, Reverse;
  logic       ShiftA, ShiftB, RSTA, Unlocked, LockedOut, Duress;
  logic [2:0] DigitCount;
  logic [1:0] Tries;

  logic [15:0] r_entry, r_stored;
  int n_asserts = 0;
  int n_fail = 0;
  int n;

  always #5 CLK = ~CLK;

  lock_controller #(
    .DIGITS(4), .MAX_TRIES(3), .UNLOCK_CYCLES(8), .LOCKOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RST(RST),
    .i_Validate(Validate), .i_Prog(Prog), .i_Lock(Lock),
    .i_Pass(Pass), .i_Reverse(Reverse),
    .o_ShiftA(ShiftA), .o_ShiftB(ShiftB), .o_RSTA(RSTA),
    .o_Unlocked(Unlocked), .o_LockedOut(LockedOut), .o_Duress(Duress),
    .o_DigitCount(DigitCount), .o_Tries(Tries)
  );

  // Combination-lock datapath: entry and stored code shift registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_entry  <= 16'h0000;
      r_stored <= 16'h1234;
    end else begin
      if (RSTA) r_entry <= 16'h0000;
      else if (ShiftA && Validate) r_entry <= {r_entry[11:0], key};
      if (ShiftB && Validate) r_stored <= {r_stored[11:0], key};
    end
  end
  assign Pass    = (r_entry == r_stored);
  assign Reverse = (r_entry == {r_stored[3:0], r_stored[7:4], r_stored[11:8], r_stored[15:12]});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key = d;
    Validate = 1'b1;
    tick();
    Validate = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] code);
    press(code[15:12]);
    press(code[11:8]);
    press(code[7:4]);
    press(code[3:0]);
  endtask

  task automatic count_unlocked(output int cnt);
    cnt = 0;
    while (Unlocked === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    do_reset();
    check("rst_rsta", RSTA, 1);
    check("rst_shifta", ShiftA, 0);
    check("rst_shiftb", ShiftB, 0);
    check("rst_unlocked", Unlocked, 0);
    check("rst_lockedout", LockedOut, 0);
    check("rst_duress", Duress, 0);
    check("rst_digits", DigitCount, 0);
    check("rst_tries", Tries, 0);
    tick();
    check("entry_shifta", ShiftA, 1);
    check("entry_rsta", RSTA, 0);

    // Correct code opens for exactly 8 cycles, then CLEAR for one
    press(4'h1); press(4'h2); press(4'h3);
    check("digits_3", DigitCount, 3);
    press(4'h4);
    check("check_shifta", ShiftA, 0);
    check("check_unlocked", Unlocked, 0);
    tick();
    check("open_unlocked", Unlocked, 1);
    check("open_tries", Tries, 0);
    count_unlocked(n);
    check("open_window_len", n, 8);
    check("after_open_rsta", RSTA, 1);
    tick();
    check("clear_one_cycle", RSTA, 0);
    check("back_to_entry", ShiftA, 1);

    // Three failures lead to a 16-cycle lockout
    enter4(16'h9999); tick();
    check("fail1_tries", Tries, 1);
    check("fail1_rsta", RSTA, 1);
    tick();
    enter4(16'h9999); tick();
    check("fail2_tries", Tries, 2);
    tick();
    enter4(16'h9999); tick();
    check("lockout_flag", LockedOut, 1);
    check("lockout_tries", Tries, 3);
    check("lockout_unlocked", Unlocked, 0);
    n = 0;
    while (LockedOut === 1'b1 && n < 40) begin
      n++;
      if (n % 3 == 1) press(4'h1); else tick();
      if (LockedOut === 1'b1) check("lockout_digits", DigitCount, 0);
    end
    check("lockout_len", n, 16);
    check("lockout_exit_tries", Tries, 0);
    check("lockout_exit_rsta", RSTA, 1);
    tick();

    // Reversed code: duress open, alarm sticky
    enter4(16'h4321); tick();
    check("duress_unlocked", Unlocked, 1);
    check("duress_flag", Duress, 1);
    count_unlocked(n);
    check("duress_window_len", n, 8);
    check("duress_sticky_close", Duress, 1);
    tick();
    enter4(16'h1234); tick();
    check("reopen_unlocked", Unlocked, 1);
    check("duress_sticky_pass", Duress, 1);
    tick(); tick();
    Lock = 1'b1; tick(); Lock = 1'b0;
    check("lock_cyc3_rsta", RSTA, 1);
    check("lock_cyc3_unlocked", Unlocked, 0);

    // Program a new code 5678
    do_reset();
    check("reset_clears_duress", Duress, 0);
    tick();
    enter4(16'h1234); tick();
    check("prog_pre_open", Unlocked, 1);
    Prog = 1'b1; tick(); Prog = 1'b0;
    check("prog_shiftb", ShiftB, 1);
    check("prog_unlocked", Unlocked, 1);
    check("prog_digits", DigitCount, 0);
    for (int i = 0; i < 12; i++) tick();
    check("prog_no_timeout", ShiftB, 1);
    n = 0;
    for (int d = 5; d <= 8; d++) begin
      if (ShiftB === 1'b1) n++;
      press(4'(d));
    end
    check("prog_shiftb_count", n, 4);
    check("prog_done_shiftb", ShiftB, 0);
    check("prog_done_rsta", RSTA, 1);
    tick();
    enter4(16'h1234); tick();
    check("old_code_fails", Tries, 1);
    check("old_code_locked", Unlocked, 0);
    tick();
    enter4(16'h5678); tick();
    check("new_code_opens", Unlocked, 1);
    check("new_code_tries", Tries, 0);
    Prog = 1'b1; Lock = 1'b1; tick(); Prog = 1'b0; Lock = 1'b0;
    check("prog_lock_rsta", RSTA, 1);
    check("prog_lock_shiftb", ShiftB, 0);

    // Reset in the middle of an entry
    tick();
    enter4(16'h9999); tick();
    check("pre_rst_tries", Tries, 1);
    tick();
    press(4'h1); press(4'h2);
    check("pre_rst_digits", DigitCount, 2);
    do_reset();
    check("mid_rst_rsta", RSTA, 1);
    check("mid_rst_digits", DigitCount, 0);
    check("mid_rst_tries", Tries, 0);
    tick();
    enter4(16'h1234); tick();
    check("post_rst_open", Unlocked, 1);

    // Palindromic code counts as a plain pass
    Prog = 1'b1; tick(); Prog = 1'b0;
    enter4(16'h1221);
    tick();
    enter4(16'h1221); tick();
    check("palin_open", Unlocked, 1);
    check("palin_no_duress", Duress, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
